branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Pipelined successor to the single-cycle branch comparator. Resolves conditional branches, jal and jalr in one registered stage.
- Computes taken, target, link and mispredict for the execute stage.
- Contains a direct-mapped 2-bit saturating branch history table (BHT). Fetch reads it combinationally; resolved conditional branches train it.

Parameters:
- AW, 32, address/PC width
- DW, 32, operand width
- BHT_DEPTH, 64, BHT entries; power of two, 2..1024
- IDX_W, $clog2(BHT_DEPTH), BHT index width (derived, localparam)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- fetch_pc  in  AW  PC looked up in the BHT
- fetch_pred_taken  out  1  combinational prediction, counter[1] of entry fetch_pc[IDX_W+1:2]
- req_valid  in  1  resolve request valid
- req_ready  out  1  unit can accept
- req_kind  in  2  00 branch, 01 jal, 10 jalr, 11 none
- req_func3  in  3  branch condition
- req_pc  in  AW  instruction PC
- req_imm  in  DW  sign-extended immediate
- req_rs1  in  DW  rs1 operand
- req_rs2  in  DW  rs2 operand
- req_pred_taken  in  1  prediction made at fetch
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts
- res_taken  out  1  redirect taken
- res_target  out  AW  redirect target
- res_link  out  DW  req_pc+4, zero-extended/truncated to DW
- res_mispredict  out  1  res_taken != req_pred_taken
- res_illegal  out  1  branch with func3 010 or 011

Behaviour:
- Handshake: valid/ready. Accept when req_valid && req_ready. req_ready = !res_valid || res_ready (single output register, no bubble under continuous flow).
- Latency: 1 cycle from accept to res_valid. Outputs hold stable while res_valid && !res_ready. res_valid clears on res_ready when there is no new accept.
- Conditions:
  - 000 eq; 001 ne.
  - 100 lt signed; 101 ge signed.
  - 110 ltu unsigned; 111 geu unsigned.
  - 010/011: taken=0, res_illegal=1.
- Kind rules:
  - branch: taken per condition; target = req_pc + req_imm[AW-1:0], modulo 2^AW.
  - jal: taken=1; target = req_pc + imm.
  - jalr: taken=1; target = (req_rs1 + req_imm) with bit 0 cleared.
  - none: taken=0, mispredict=0, target = req_pc + 4.
- res_link is always req_pc+4; wraps at 2^AW.
- BHT training: only on an accepted kind==branch with a legal func3. Index = req_pc[IDX_W+1:2]; counter +1 if taken, -1 if not; saturate at 2'b11 and 2'b00.
- BHT read: fetch_pred_taken reads the pre-update value. A same-cycle update to the same index is visible the next cycle; no bypass.
- Reset: res_valid=0; res_taken, res_target, res_link, res_mispredict, res_illegal = 0. All BHT entries = 2'b01 (weakly not-taken), written in one cycle.
- Reset mid-operation: a held, unconsumed result is dropped. A request presented during rst is not accepted, and req_ready=0 while rst=1.

Optional Feature:
- Macro: BRANCH_RESOLVE_PERF_EN.
- With it: adds outputs perf_resolved and perf_mispredicts, each 32 bits.
  - perf_resolved increments on each accepted branch/jal/jalr.
  - perf_mispredicts increments when that accept yields mispredict.
  - Both wrap at 2^32 and clear on rst.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package branch_pkg:
  - br_kind_e enum (BR_BRANCH, BR_JAL, BR_JALR, BR_NONE).
  - br_func3_e constants for the six conditions.
  - bht_ctr_t (2-bit) with BHT_RESET_VAL=2'b01.
- One sub-module: branch_bht (counter array, combinational read port, saturating update port, synchronous reset).
- Compare, target and handshake logic stay in the top.

Test Plan:
- Signed vs unsigned compare: rs1=32'hFFFF_FFFF, rs2=1. func3=100 gives taken=1; func3=110 gives taken=0; both with res_valid one cycle after accept.
- jalr alignment: rs1=32'h1001, imm=2 gives target=32'h1002, taken=1, link=pc+4. With req_pred_taken=0, mispredict=1.
- BHT saturation: after reset, pred=0 at pc=0x40. Two taken branches at 0x40 give pred=1. A third taken keeps counter 11, and one not-taken leaves pred=1. A pc aliasing 0x40 (0x40 + 4*BHT_DEPTH) returns the same prediction.
- Backpressure: hold res_ready=0 with a new req_valid=1. Expect req_ready=0 and res_* stable for 5 cycles; raise res_ready and the next result appears the following cycle. Streaming with res_ready=1 gives one result per cycle.
- Illegal/kind none: func3=010 branch gives taken=0, illegal=1, and the BHT entry is unchanged. kind=none gives mispredict=0, target=pc+4.
- Reset mid-stream: assert rst while res_valid=1 and res_ready=0. Next cycle res_valid=0 and all BHT entries read pred=0; with the perf macro, both counters read 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit.
//   br_kind_e     : request kind (branch, jal, jalr, none)
//   br_func3_e    : the six legal conditional-branch conditions
//   bht_ctr_t     : 2-bit saturating branch history counter
//   BHT_RESET_VAL : weakly not-taken
//   func3_legal() : 1 for the six defined conditions, 0 for 010/011
package branch_pkg;

  typedef enum logic [1:0] {
    BR_BRANCH = 2'b00,
    BR_JAL    = 2'b01,
    BR_JALR   = 2'b10,
    BR_NONE   = 2'b11
  } br_kind_e;

  typedef enum logic [2:0] {
    F3_EQ  = 3'b000,
    F3_NE  = 3'b001,
    F3_LT  = 3'b100,
    F3_GE  = 3'b101,
    F3_LTU = 3'b110,
    F3_GEU = 3'b111
  } br_func3_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET_VAL = 2'b01;

  function automatic logic func3_legal(input logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Direct-mapped branch history table of 2-bit saturating counters.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (all entries -> 01)
//   i_rd_idx      : combinational read index
//   o_rd_taken    : MSB of the addressed counter (pre-update value)
//   i_upd_en      : train the entry at i_upd_idx this cycle
//   i_upd_idx     : training index
//   i_upd_taken   : 1 = count up, 0 = count down (saturating)
module branch_bht
  import branch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  bht_ctr_t r_ctr [DEPTH];
  bht_ctr_t w_cur;

  // Read is straight from the array: a same-cycle update becomes visible
  // only on the following cycle.
  assign o_rd_taken = r_ctr[i_rd_idx][1];
  assign w_cur      = r_ctr[i_upd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= BHT_RESET_VAL;
      end
    end else if (i_upd_en) begin
      if (i_upd_taken && (w_cur != 2'b11)) begin
        r_ctr[i_upd_idx] <= w_cur + 2'd1;
      end else if (!i_upd_taken && (w_cur != 2'b00)) begin
        r_ctr[i_upd_idx] <= w_cur - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: one registered stage that resolves conditional
// branches, jal and jalr, producing taken/target/link/mispredict/illegal,
// and trains a direct-mapped 2-bit BHT that fetch reads combinationally.
//
// Handshake (both sides): a transfer happens on a cycle where valid and
// ready are both high. valid must not depend on ready. The result register
// holds its contents while res_valid && !res_ready. req_ready is
// !rst && (!res_valid || res_ready), so a continuous stream flows at one
// result per cycle with no bubble.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   fetch_pc            : fetch lookup PC; fetch_pred_taken = counter MSB
//   req_*               : resolve request (kind, func3, pc, imm, rs1, rs2,
//                         fetch prediction), valid/ready
//   res_*               : registered result, valid/ready
//   perf_resolved       : (BRANCH_RESOLVE_PERF_EN only) accepted branch/jal/jalr
//   perf_mispredicts    : (BRANCH_RESOLVE_PERF_EN only) accepted mispredicts
//
// Build option: define BRANCH_RESOLVE_PERF_EN to add the two 32-bit
// wrapping performance counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] fetch_pc,
  output logic          fetch_pred_taken,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_kind,
  input  logic [2:0]    req_func3,
  input  logic [AW-1:0] req_pc,
  input  logic [DW-1:0] req_imm,
  input  logic [DW-1:0] req_rs1,
  input  logic [DW-1:0] req_rs2,
  input  logic          req_pred_taken,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_taken,
  output logic [AW-1:0] res_target,
  output logic [DW-1:0] res_link,
  output logic          res_mispredict,
  output logic          res_illegal
`ifdef BRANCH_RESOLVE_PERF_EN
  ,
  output logic [31:0]   perf_resolved,
  output logic [31:0]   perf_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // Result register
  logic          r_valid;
  logic          r_taken;
  logic [AW-1:0] r_target;
  logic [DW-1:0] r_link;
  logic          r_mispredict;
  logic          r_illegal;

  // Combinational resolve path
  br_kind_e      w_kind;
  logic          w_accept;
  logic          w_f3_legal;
  logic          w_eq, w_lt, w_ltu;
  logic          w_cond;
  logic          w_taken;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_pc_plus4;
  logic [AW-1:0] w_imm_aw;
  logic [DW-1:0] w_jalr_sum;
  logic [AW-1:0] w_jalr_aw;
  logic          w_mispredict;
  logic          w_illegal;
  logic          w_bht_upd;
  logic          w_unused_fetch_bits;

  assign w_kind     = br_kind_e'(req_kind);
  assign req_ready  = !rst && (!r_valid || res_ready);
  assign w_accept   = req_valid && req_ready;
  assign w_f3_legal = func3_legal(req_func3);

  assign w_eq  = (req_rs1 == req_rs2);
  assign w_lt  = ($signed(req_rs1) < $signed(req_rs2));
  assign w_ltu = (req_rs1 < req_rs2);

  // Immediate is sign-extended or truncated to the address width.
  assign w_imm_aw   = AW'($signed(req_imm));
  assign w_pc_plus4 = req_pc + AW'(4);
  assign w_jalr_sum = req_rs1 + req_imm;
  assign w_jalr_aw  = AW'(w_jalr_sum);

  always_comb begin
    w_cond = 1'b0;
    case (req_func3)
      F3_EQ:   w_cond = w_eq;
      F3_NE:   w_cond = !w_eq;
      F3_LT:   w_cond = w_lt;
      F3_GE:   w_cond = !w_lt;
      F3_LTU:  w_cond = w_ltu;
      F3_GEU:  w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_taken   = 1'b0;
    w_target  = w_pc_plus4;
    w_illegal = 1'b0;
    case (w_kind)
      BR_BRANCH: begin
        w_taken   = w_cond;
        w_target  = req_pc + w_imm_aw;
        w_illegal = !w_f3_legal;
      end
      BR_JAL: begin
        w_taken  = 1'b1;
        w_target = req_pc + w_imm_aw;
      end
      BR_JALR: begin
        w_taken  = 1'b1;
        w_target = {w_jalr_aw[AW-1:1], 1'b0};
      end
      default: begin
        w_taken  = 1'b0;
        w_target = w_pc_plus4;
      end
    endcase
  end

  assign w_mispredict = (w_kind != BR_NONE) && (w_taken != req_pred_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= '0;
      r_link       <= '0;
      r_mispredict <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_taken      <= w_taken;
      r_target     <= w_target;
      r_link       <= DW'(w_pc_plus4);
      r_mispredict <= w_mispredict;
      r_illegal    <= w_illegal;
    end else if (res_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign res_valid      = r_valid;
  assign res_taken      = r_taken;
  assign res_target     = r_target;
  assign res_link       = r_link;
  assign res_mispredict = r_mispredict;
  assign res_illegal    = r_illegal;

  // Only legal conditional branches train the predictor.
  assign w_bht_upd = w_accept && (w_kind == BR_BRANCH) && w_f3_legal;

  // PC bits outside the word index do not select a BHT entry.
  assign w_unused_fetch_bits = ^{fetch_pc[AW-1:IDX_W+2], fetch_pc[1:0]};

  branch_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (fetch_pc[IDX_W+1:2]),
    .o_rd_taken  (fetch_pred_taken),
    .i_upd_en    (w_bht_upd),
    .i_upd_idx   (req_pc[IDX_W+1:2]),
    .i_upd_taken (w_taken)
  );

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] r_perf_resolved;
  logic [31:0] r_perf_mispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_resolved    <= '0;
      r_perf_mispredicts <= '0;
    end else if (w_accept && (w_kind != BR_NONE)) begin
      r_perf_resolved <= r_perf_resolved + 32'd1;
      if (w_mispredict) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign perf_resolved    = r_perf_resolved;
  assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model (expected-result queue,
// integer BHT counter array, perf counts).
module tb_branch_resolve_unit;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int BHT_DEPTH = 64;
  localparam int RW        = 1 + AW + DW + 1 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [AW-1:0] fetch_pc;
  logic          fetch_pred_taken;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_kind;
  logic [2:0]    req_func3;
  logic [AW-1:0] req_pc;
  logic [DW-1:0] req_imm;
  logic [DW-1:0] req_rs1;
  logic [DW-1:0] req_rs2;
  logic          req_pred_taken;
  logic          res_valid;
  logic          res_ready;
  logic          res_taken;
  logic [AW-1:0] res_target;
  logic [DW-1:0] res_link;
  logic          res_mispredict;
  logic          res_illegal;
`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0]   perf_resolved;
  logic [31:0]   perf_mispredicts;
`endif

  branch_resolve_unit #(
    .AW        (AW),
    .DW        (DW),
    .BHT_DEPTH (BHT_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .fetch_pred_taken (fetch_pred_taken),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_kind         (req_kind),
    .req_func3        (req_func3),
    .req_pc           (req_pc),
    .req_imm          (req_imm),
    .req_rs1          (req_rs1),
    .req_rs2          (req_rs2),
    .req_pred_taken   (req_pred_taken),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .res_link         (res_link),
    .res_mispredict   (res_mispredict),
    .res_illegal      (res_illegal)
`ifdef BRANCH_RESOLVE_PERF_EN
    ,
    .perf_resolved    (perf_resolved),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  // ---------------- scoreboard / model ----------------
  logic [RW-1:0] exp_q[$];
  int            bht_m [BHT_DEPTH];
  int unsigned   m_resolved;
  int unsigned   m_mispredicts;
  int            n_cmp  = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result bundle: {taken, target, link, mispredict, illegal}
  function automatic logic [RW-1:0] ref_result(input logic [1:0] k, input logic [2:0] f3,
                                               input logic [31:0] pc, input logic [31:0] imm,
                                               input logic [31:0] rs1, input logic [31:0] rs2,
                                               input logic pred);
    int          s1;
    int          s2;
    logic        t;
    logic        ill;
    logic        mp;
    logic [31:0] tgt;
    s1  = rs1;
    s2  = rs2;
    t   = 1'b0;
    ill = 1'b0;
    tgt = pc + 32'd4;
    if (k == 2'd0) begin
      tgt = pc + imm;
      case (f3)
        3'd0: t = (rs1 == rs2);
        3'd1: t = (rs1 != rs2);
        3'd4: t = (s1 < s2);
        3'd5: t = (s1 >= s2);
        3'd6: t = (rs1 < rs2);
        3'd7: t = (rs1 >= rs2);
        default: ill = 1'b1;
      endcase
    end else if (k == 2'd1) begin
      t   = 1'b1;
      tgt = pc + imm;
    end else if (k == 2'd2) begin
      t   = 1'b1;
      tgt = (rs1 + imm) & 32'hFFFF_FFFE;
    end
    mp = (k != 2'd3) && (t != pred);
    return {t, tgt, pc + 32'd4, mp, ill};
  endfunction

  function automatic int bht_idx(input logic [31:0] pc);
    return int'((pc / 4) % BHT_DEPTH);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
    m_resolved    = 0;
    m_mispredicts = 0;
  endtask

  // One clock cycle: check outputs at the negedge, then advance the model
  // across the posedge; returns 1 time unit after the edge.
  task automatic step();
    logic          exp_ready;
    logic          acc;
    logic [RW-1:0] r;
    logic [RW-1:0] e;
    int            ix;
    @(negedge clk);
    exp_ready = !rst && (exp_q.size() == 0 || res_ready);
    check("req_ready", RW'(req_ready), RW'(exp_ready));
    check("res_valid", RW'(res_valid), RW'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("res_taken",      RW'(res_taken),      RW'(e[RW-1]));
      check("res_target",     RW'(res_target),     RW'(e[RW-2 -: AW]));
      check("res_link",       RW'(res_link),       RW'(e[DW+1:2]));
      check("res_mispredict", RW'(res_mispredict), RW'(e[1]));
      check("res_illegal",    RW'(res_illegal),    RW'(e[0]));
    end
    check("fetch_pred", RW'(fetch_pred_taken), RW'(bht_m[bht_idx(fetch_pc)] >= 2));
`ifdef BRANCH_RESOLVE_PERF_EN
    check("perf_resolved",    RW'(perf_resolved),    RW'(m_resolved));
    check("perf_mispredicts", RW'(perf_mispredicts), RW'(m_mispredicts));
`endif
    acc = req_valid && exp_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (exp_q.size() != 0 && res_ready) void'(exp_q.pop_front());
      if (acc) begin
        r = ref_result(req_kind, req_func3, req_pc, req_imm, req_rs1, req_rs2, req_pred_taken);
        exp_q.push_back(r);
        if (req_kind != 2'd3) begin
          m_resolved++;
          if (r[1]) m_mispredicts++;
        end
        if (req_kind == 2'd0 && !r[0]) begin
          ix = bht_idx(req_pc);
          if (r[RW-1] && bht_m[ix] < 3) bht_m[ix]++;
          else if (!r[RW-1] && bht_m[ix] > 0) bht_m[ix]--;
        end
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic pred);
    req_valid      = 1'b1;
    req_kind       = k;
    req_func3      = f3;
    req_pc         = pc;
    req_imm        = imm;
    req_rs1        = rs1;
    req_rs2        = rs2;
    req_pred_taken = pred;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rs1_v;
    rst = 1'b1;
    fetch_pc = '0;
    res_ready = 1'b1;
    req_valid = 1'b0;
    req_kind = 2'd3;
    req_func3 = '0;
    req_pc = '0;
    req_imm = '0;
    req_rs1 = '0;
    req_rs2 = '0;
    req_pred_taken = 1'b0;
    model_reset();

    // Reset state
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_res_valid",  RW'(res_valid),      RW'(0));
    check("rst_res_taken",  RW'(res_taken),      RW'(0));
    check("rst_res_target", RW'(res_target),     RW'(0));
    check("rst_res_link",   RW'(res_link),       RW'(0));
    check("rst_res_misp",   RW'(res_mispredict), RW'(0));
    check("rst_res_ill",    RW'(res_illegal),    RW'(0));
    step();

    // Signed vs unsigned compare
    drive(2'd0, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0);
    step();
    idle();
    check("blt_valid", RW'(res_valid), RW'(1));
    check("blt_taken", RW'(res_taken), RW'(1));
    drive(2'd0, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0);
    step();
    idle();
    check("bltu_valid", RW'(res_valid), RW'(1));
    check("bltu_taken", RW'(res_taken), RW'(0));
    step();

    // jalr alignment
    drive(2'd2, 3'b000, 32'h200, 32'h2, 32'h1001, 32'h0, 1'b0);
    step();
    idle();
    check("jalr_target", RW'(res_target),     RW'(32'h1002));
    check("jalr_taken",  RW'(res_taken),      RW'(1));
    check("jalr_link",   RW'(res_link),       RW'(32'h204));
    check("jalr_misp",   RW'(res_mispredict), RW'(1));
    step();

    // BHT saturation at pc 0x40
    fetch_pc = 32'h40;
    #1;
    check("bht_init_pred", RW'(fetch_pred_taken), RW'(0));
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 3'b000, 32'h40, 32'h8, 32'h5, 32'h5, 1'b0);
      step();
    end
    idle();
    check("bht_taken3_pred", RW'(fetch_pred_taken), RW'(1));
    drive(2'd0, 3'b001, 32'h40, 32'h8, 32'h5, 32'h5, 1'b1);
    step();
    idle();
    check("bht_nt_pred", RW'(fetch_pred_taken), RW'(1));
    fetch_pc = 32'h40 + 4 * BHT_DEPTH;
    #1;
    check("bht_alias_pred", RW'(fetch_pred_taken), RW'(1));
    fetch_pc = 32'h40;

    // Illegal func3 leaves the entry alone; one more not-taken then drops it
    drive(2'd0, 3'b010, 32'h40, 32'h8, 32'h5, 32'h5, 1'b1);
    step();
    idle();
    check("ill_taken",   RW'(res_taken),        RW'(0));
    check("ill_illegal", RW'(res_illegal),      RW'(1));
    check("ill_bht",     RW'(fetch_pred_taken), RW'(1));
    drive(2'd0, 3'b001, 32'h40, 32'h8, 32'h5, 32'h5, 1'b1);
    step();
    idle();
    check("bht_after_ill_nt", RW'(fetch_pred_taken), RW'(0));

    // kind none
    drive(2'd3, 3'b000, 32'h300, 32'h40, 32'h1, 32'h1, 1'b1);
    step();
    idle();
    check("none_misp",   RW'(res_mispredict), RW'(0));
    check("none_target", RW'(res_target),     RW'(32'h304));
    check("none_taken",  RW'(res_taken),      RW'(0));
    step();

    // Backpressure
    res_ready = 1'b0;
    drive(2'd1, 3'b000, 32'h400, 32'h10, 32'h0, 32'h0, 1'b1);
    step();
    drive(2'd1, 3'b000, 32'h500, 32'h20, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_req_ready", RW'(req_ready),  RW'(0));
      check("bp_hold_tgt",  RW'(res_target), RW'(32'h410));
      check("bp_hold_vld",  RW'(res_valid),  RW'(1));
    end
    res_ready = 1'b1;
    step();
    idle();
    check("bp_next_vld", RW'(res_valid),  RW'(1));
    check("bp_next_tgt", RW'(res_target), RW'(32'h520));

    // Streaming, one result per cycle
    for (int i = 0; i < 4; i++) begin
      drive(2'd1, 3'b000, 32'h800 + 32'(i * 4), 32'h100, 32'h0, 32'h0, 1'b1);
      step();
      check("stream_vld", RW'(res_valid),  RW'(1));
      check("stream_tgt", RW'(res_target), RW'(32'h900 + 32'(i * 4)));
    end
    idle();
    step();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rs1_v = $urandom();
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 255)) << 2,
            32'($signed(12'($urandom_range(0, 4095)))),
            rs1_v,
            ($urandom_range(0, 1) == 1) ? rs1_v : $urandom(),
            1'($urandom_range(0, 1)));
      req_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      fetch_pc  = 32'($urandom_range(0, 255)) << 2;
      step();
    end

    // Reset while a result is held
    res_ready = 1'b0;
    drive(2'd1, 3'b000, 32'h600, 32'h4, 32'h0, 32'h0, 1'b0);
    step();
    step();
    check("mid_pre_vld", RW'(res_valid), RW'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    res_ready = 1'b1;
    check("mid_rst_vld",   RW'(res_valid), RW'(0));
    check("mid_rst_taken", RW'(res_taken), RW'(0));
`ifdef BRANCH_RESOLVE_PERF_EN
    check("mid_rst_perf_res",  RW'(perf_resolved),    RW'(0));
    check("mid_rst_perf_misp", RW'(perf_mispredicts), RW'(0));
`endif
    for (int i = 0; i < BHT_DEPTH; i++) begin
      fetch_pc = 32'(i * 4);
      #1;
      check("mid_rst_bht", RW'(fetch_pred_taken), RW'(0));
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
